// File: rtl/shiftright_seq_32_pkg.sv
// ============================================================================
// shiftright_seq_32_pkg : shared widths and FSM encoding for the serial shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

package shiftright_seq_32_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shiftright_seq_32_if.sv
// ============================================================================
// shiftright_seq_32_if : start/busy/done request bus of the serial shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shiftright_seq_32_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shift;
  logic             arith;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, a, shift, arith,
    input  busy, done, out
  );

  modport slave (
    input  start, a, shift, arith,
    output busy, done, out
  );

endinterface

`default_nettype wire

// File: rtl/shiftright_seq_32_shr1.sv
// ============================================================================
// shr1_32 : single-position right shift with selectable fill bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module shr1_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  input  logic             fill,
  output logic [WIDTH-1:0] y
);

  assign y = {fill, d[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/shiftright_seq_32.sv
// ============================================================================
// shiftright_seq_32 : iterative right shifter, one bit per clock, logical/arith
// Revision: 1.0
// ============================================================================
`default_nettype none

module shiftright_seq_32
  import shiftright_seq_32_pkg::*;
#(
  parameter int WIDTH = shiftright_seq_32_pkg::WIDTH,
  parameter int SHW   = shiftright_seq_32_pkg::SHW
) (
  input  logic                clk,
  input  logic                rst_n,
  shiftright_seq_32_if.slave  bus
);

  if (WIDTH != (2 ** SHW)) begin : g_width_check
    $error("shiftright_seq_32: WIDTH must equal 2**SHW");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_shr;
  logic [WIDTH-1:0] out_q;
  logic [SHW-1:0]   cnt;
  logic             fill;

  shr1_32 #(
    .WIDTH (WIDTH)
  ) u_shr1 (
    .d    (acc),
    .fill (fill),
    .y    (acc_shr)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = (bus.shift != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt == SHW'(1)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operands are latched only in IDLE, so a start while busy has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc  <= bus.a;
            cnt  <= bus.shift;
            fill <= bus.arith & bus.a[WIDTH-1];
            if (bus.shift == '0) begin
              out_q <= bus.a;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_shr;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            out_q <= acc_shr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.out  = out_q;

endmodule

`default_nettype wire
